// File: rtl/uart_cfg.sv
// Configurable full-duplex UART between AXI4-Stream and serial pins (5..9 data bits, parity, 1/2 stop).
// Latency: txd start bit one cycle after accept; RX word valid at the mid-point of the first stop bit.
// Backpressure: TX tready low for the whole frame; an unconsumed RX word is overwritten and flagged as overrun.
module uart_cfg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  input  logic                  rxd,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error,
  output logic                  rx_parity_error,
  output logic                  rx_break,
  input  logic [15:0]           prescale,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  // Bit period and half-bit wait derived from the live configuration; prescale 0 acts as 1.
  logic [15:0] pre_eff;
  logic [18:0] period_d;
  logic [18:0] half_d;
  logic        par_en_d;
  logic        odd_d;

  assign pre_eff  = (prescale == 16'd0) ? 16'd1 : prescale;
  assign period_d = {pre_eff, 3'b000};
  assign half_d   = {1'b0, pre_eff, 2'b00} - 19'd1;
  assign par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign odd_d    = (parity_mode == 2'b10);

  // ---------------- transmitter ----------------
  tx_state_t    tx_state_q;
  logic [18:0]  tx_cnt_q;
  logic [18:0]  tx_period_q;
  logic [3:0]   tx_bits_q;
  logic [W-1:0] tx_shift_q;
  logic         tx_par_q;
  logic         tx_par_en_q;
  logic         tx_two_stop_q;
  logic         txd_q;
  logic         tx_rdy_q;
  logic         tx_busy_q;

  // TX frame sequencer; each bit is held for tx_period_q cycles, config frozen at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_period_q   <= '0;
      tx_bits_q     <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      tx_par_en_q   <= 1'b0;
      tx_two_stop_q <= 1'b0;
      txd_q         <= 1'b1;
      tx_rdy_q      <= 1'b0;
      tx_busy_q     <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          txd_q     <= 1'b1;
          tx_busy_q <= 1'b0;
          if (tx_rdy_q && input_axis_tvalid) begin
            tx_rdy_q      <= 1'b0;
            tx_busy_q     <= 1'b1;
            txd_q         <= 1'b0;
            tx_shift_q    <= input_axis_tdata;
            tx_par_q      <= (^input_axis_tdata) ^ odd_d;
            tx_par_en_q   <= par_en_d;
            tx_two_stop_q <= stop_bits;
            tx_period_q   <= period_d;
            tx_cnt_q      <= period_d - 19'd1;
            tx_state_q    <= TX_START;
          end else begin
            tx_rdy_q <= 1'b1;
          end
        end
        default: begin
          if (tx_cnt_q != 19'd0) begin
            tx_cnt_q <= tx_cnt_q - 19'd1;
          end else begin
            tx_cnt_q <= tx_period_q - 19'd1;
            case (tx_state_q)
              TX_START: begin
                txd_q      <= tx_shift_q[0];
                tx_shift_q <= tx_shift_q >> 1;
                tx_bits_q  <= 4'(W - 1);
                tx_state_q <= TX_DATA;
              end
              TX_DATA: begin
                if (tx_bits_q != 4'd0) begin
                  txd_q      <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_bits_q  <= tx_bits_q - 4'd1;
                end else if (tx_par_en_q) begin
                  txd_q      <= tx_par_q;
                  tx_state_q <= TX_PARITY;
                end else begin
                  txd_q      <= 1'b1;
                  tx_state_q <= TX_STOP1;
                end
              end
              TX_PARITY: begin
                txd_q      <= 1'b1;
                tx_state_q <= TX_STOP1;
              end
              TX_STOP1: begin
                if (tx_two_stop_q) begin
                  tx_state_q <= TX_STOP2;
                end else begin
                  tx_state_q <= TX_IDLE;
                  tx_rdy_q   <= 1'b1;
                  tx_busy_q  <= 1'b0;
                end
              end
              default: begin
                tx_state_q <= TX_IDLE;
                tx_rdy_q   <= 1'b1;
                tx_busy_q  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t    rx_state_q;
  logic [18:0]  rx_cnt_q;
  logic [18:0]  rx_period_q;
  logic [3:0]   rx_bits_q;
  logic [W-1:0] rx_shift_q;
  logic         rx_par_bit_q;
  logic         rx_par_en_q;
  logic         rx_odd_q;
  logic [W-1:0] out_dat_q;
  logic         out_vld_q;
  logic         rx_busy_q;
  logic         ovr_q;
  logic         frm_q;
  logic         perr_q;
  logic         brk_q;
  logic         rx_perr_d;

  assign rx_perr_d = rx_par_en_q & ((^rx_shift_q) ^ rx_par_bit_q ^ rx_odd_q);

  // RX sampler: qualify start at half-bit, then one mid-bit sample per bit; error pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_period_q  <= '0;
      rx_bits_q    <= '0;
      rx_shift_q   <= '0;
      rx_par_bit_q <= 1'b0;
      rx_par_en_q  <= 1'b0;
      rx_odd_q     <= 1'b0;
      out_dat_q    <= '0;
      out_vld_q    <= 1'b0;
      rx_busy_q    <= 1'b0;
      ovr_q        <= 1'b0;
      frm_q        <= 1'b0;
      perr_q       <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      ovr_q  <= 1'b0;
      frm_q  <= 1'b0;
      perr_q <= 1'b0;
      brk_q  <= 1'b0;
      if (out_vld_q && output_axis_tready) begin
        out_vld_q <= 1'b0;
      end
      case (rx_state_q)
        RX_IDLE: begin
          if (!rxd) begin
            rx_busy_q   <= 1'b1;
            rx_period_q <= period_d;
            rx_par_en_q <= par_en_d;
            rx_odd_q    <= odd_d;
            rx_cnt_q    <= half_d;
            rx_state_q  <= RX_START;
          end
        end
        RX_WAIT_IDLE: begin
          if (rxd) begin
            rx_busy_q  <= 1'b0;
            rx_state_q <= RX_IDLE;
          end
        end
        default: begin
          if (rx_cnt_q != 19'd0) begin
            rx_cnt_q <= rx_cnt_q - 19'd1;
          end else begin
            rx_cnt_q <= rx_period_q - 19'd1;
            case (rx_state_q)
              RX_START: begin
                if (!rxd) begin
                  rx_bits_q  <= 4'(W);
                  rx_state_q <= RX_DATA;
                end else begin
                  rx_busy_q  <= 1'b0;
                  rx_state_q <= RX_IDLE;
                end
              end
              RX_DATA: begin
                rx_shift_q <= {rxd, rx_shift_q[W-1:1]};
                rx_bits_q  <= rx_bits_q - 4'd1;
                if (rx_bits_q == 4'd1) begin
                  rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
                end
              end
              RX_PARITY: begin
                rx_par_bit_q <= rxd;
                rx_state_q   <= RX_STOP;
              end
              default: begin
                if (rxd) begin
                  if (rx_perr_d) begin
                    perr_q <= 1'b1;
                  end else begin
                    out_dat_q <= rx_shift_q;
                    out_vld_q <= 1'b1;
                    ovr_q     <= out_vld_q && !output_axis_tready;
                  end
                  rx_busy_q  <= 1'b0;
                  rx_state_q <= RX_IDLE;
                end else begin
                  frm_q      <= 1'b1;
                  perr_q     <= rx_perr_d;
                  brk_q      <= (rx_shift_q == '0) && !(rx_par_en_q && rx_par_bit_q);
                  rx_state_q <= RX_WAIT_IDLE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign input_axis_tready  = tx_rdy_q;
  assign txd                = txd_q;
  assign tx_busy            = tx_busy_q;
  assign output_axis_tdata  = out_dat_q;
  assign output_axis_tvalid = out_vld_q;
  assign rx_busy            = rx_busy_q;
  assign rx_overrun_error   = ovr_q;
  assign rx_frame_error     = frm_q;
  assign rx_parity_error    = perr_q;
  assign rx_break           = brk_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: TX serial waveform and RX events checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_cfg;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_dat;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] out_dat;
  logic         out_vld;
  logic         out_rdy;
  logic         rxd;
  logic         txd;
  logic         tx_busy, rx_busy;
  logic         ovr, frm, perr, brk;
  logic [15:0]  prescale;
  logic [1:0]   parity_mode;
  logic         stop_bits;
  logic         loop;
  logic         rxd_drv;

  always #5 clk = ~clk;
  assign rxd = loop ? txd : rxd_drv;

  uart_cfg #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(in_dat), .input_axis_tvalid(in_vld), .input_axis_tready(in_rdy),
    .output_axis_tdata(out_dat), .output_axis_tvalid(out_vld), .output_axis_tready(out_rdy),
    .rxd(rxd), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .rx_overrun_error(ovr), .rx_frame_error(frm), .rx_parity_error(perr), .rx_break(brk),
    .prescale(prescale), .parity_mode(parity_mode), .stop_bits(stop_bits)
  );

  typedef struct {
    logic [7:0] dat;
    int         p;
    int         pm;
    int         sb;
  } tx_exp_t;

  typedef struct packed {
    logic       ovr;
    logic       par;
    logic       frm;
    logic       brk;
    logic       dv;
    logic [7:0] dat;
  } rx_ev_t;

  tx_exp_t txq[$];
  rx_ev_t  rxq[$];
  int      n_chk = 0;
  int      n_fail = 0;
  bit      tx_mon_en = 1'b1;
  bit      rx_pending = 1'b0;
  int      cur_p, cur_pm, cur_sb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ones(input logic [7:0] d);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(d[i]);
    return c;
  endfunction

  function automatic int period(input int p);
    return 8 * ((p == 0) ? 1 : p);
  endfunction

  function automatic bit par_on(input int pm);
    return (pm == 1) || (pm == 2);
  endfunction

  function automatic logic par_val(input logic [7:0] d, input int pm);
    return logic'((ones(d) % 2) != 0) ^ logic'(pm == 2);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int p, input int pm, input int sb);
    cur_p = p; cur_pm = pm; cur_sb = sb;
    prescale = 16'(p); parity_mode = 2'(pm); stop_bits = 1'(sb);
  endtask

  // A correctly framed word: overrun expected when the previous word is still unconsumed.
  task automatic push_good(input logic [7:0] d);
    rx_ev_t e;
    e = '0;
    e.dv  = 1'b1;
    e.dat = d;
    e.ovr = rx_pending && !out_rdy;
    rx_pending = !out_rdy;
    rxq.push_back(e);
  endtask

  task automatic tx_send(input logic [7:0] d);
    tx_exp_t e;
    int k;
    e.dat = d; e.p = cur_p; e.pm = cur_pm; e.sb = cur_sb;
    txq.push_back(e);
    if (loop) push_good(d);
    in_dat = d;
    in_vld = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_rdy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("tx_accept", in_rdy, 1);
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    @(negedge clk);
    while (!(in_rdy && !tx_busy && !rx_busy) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", in_rdy && !tx_busy && !rx_busy, 1);
    repeat (3) tick();
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit bad_par, input bit stop_val);
    int     T;
    logic   pb;
    rx_ev_t e;
    T  = period(cur_p);
    pb = par_val(d, cur_pm) ^ logic'(bad_par);
    if (stop_val && !(bad_par && par_on(cur_pm))) begin
      push_good(d);
    end else begin
      e = '0;
      e.frm = !stop_val;
      e.par = bad_par && par_on(cur_pm);
      e.brk = !stop_val && (d == 8'h00) && !(par_on(cur_pm) && pb);
      rxq.push_back(e);
    end
    rxd_drv = 1'b0;
    repeat (T) tick();
    for (int i = 0; i < W; i++) begin
      rxd_drv = d[i];
      repeat (T) tick();
    end
    if (par_on(cur_pm)) begin
      rxd_drv = pb;
      repeat (T) tick();
    end
    rxd_drv = logic'(stop_val);
    repeat (T) tick();
    rxd_drv = 1'b1;
    repeat (2 * T) tick();
  endtask

  // TX monitor: on each accept, checks txd/busy/tready on every cycle of the expected frame.
  initial begin
    bit      pending;
    tx_exp_t e;
    logic    fb[16];
    int      n, T, errs, first;
    logic    first_act, first_exp;
    pending = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (!rst && tx_mon_en && in_vld && in_rdy) begin
        check("tx_accept_expected", txq.size() > 0, 1);
        if (txq.size() > 0) begin
          e = txq.pop_front();
          n = 0;
          fb[n] = 1'b0; n++;
          for (int i = 0; i < W; i++) begin fb[n] = e.dat[i]; n++; end
          if (par_on(e.pm)) begin fb[n] = par_val(e.dat, e.pm); n++; end
          fb[n] = 1'b1; n++;
          if (e.sb != 0) begin fb[n] = 1'b1; n++; end
          T = period(e.p);
          errs = 0; first = -1; first_act = 1'b0; first_exp = 1'b0;
          for (int c = 0; c < n * T; c++) begin
            @(negedge clk);
            if (txd !== fb[c / T] || tx_busy !== 1'b1 || in_rdy !== 1'b0) begin
              if (errs == 0) begin first = c; first_act = txd; first_exp = fb[c / T]; end
              errs++;
            end
          end
          n_chk++;
          if (errs != 0) begin
            n_fail++;
            $display("FAIL tx_frame data=0x%0h: %0d bad cycles, first at %0d (txd=%b, expected %b, busy=1, tready=0)",
                     e.dat, errs, first, first_act, first_exp);
          end
          @(negedge clk);
          check("tx_end_txd_busy_rdy", {txd, tx_busy, in_rdy}, 3'b101);
          pending = 1'b1;
        end
      end
    end
  end

  // RX monitor: any new word or error pulse is one event, compared with the next expected event.
  initial begin
    logic   pv, pr, nw;
    rx_ev_t a, e;
    pv = 1'b0; pr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; pr = 1'b0;
      end else begin
        nw = (out_vld && !(pv && !pr)) || ovr;
        if (nw || perr || frm || brk) begin
          a = '0;
          a.ovr = ovr; a.par = perr; a.frm = frm; a.brk = brk; a.dv = nw;
          a.dat = nw ? out_dat : 8'h00;
          if (rxq.size() == 0) begin
            check("rx_unexpected_event", 32'(a), 0);
          end else begin
            e = rxq.pop_front();
            check("rx_event", 32'(a), 32'(e));
          end
        end
        pv = out_vld; pr = out_rdy;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_dat = '0; in_vld = 1'b0; out_rdy = 1'b1; loop = 1'b0; rxd_drv = 1'b1;
    set_cfg(1, 0, 0);
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tready", in_rdy, 0);
    check("rst_busy", {tx_busy, rx_busy}, 0);
    check("rst_rx_out", {out_vld, out_dat}, 0);
    check("rst_pulses", {ovr, frm, perr, brk}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_rst", in_rdy, 1);
    tick();

    // Loopback: directed frames, then random data and configuration.
    loop = 1'b1;
    set_cfg(1, 0, 0);
    tx_send(8'hA5);
    wait_idle();
    set_cfg(2, 1, 1);
    tx_send(8'h07);
    tx_send(8'h3B);
    wait_idle();
    set_cfg(1, 2, 0);
    tx_send(8'h5A);
    tx_send(8'h00);
    tx_send(8'hFF);
    wait_idle();
    set_cfg(0, 3, 1);
    tx_send(8'hC3);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      tx_send(8'($urandom));
      wait_idle();
    end
    loop = 1'b0;
    rxd_drv = 1'b1;
    repeat (4) tick();

    // Parity error, then parity and stop errors together.
    set_cfg(1, 1, 0);
    rx_frame(8'h3C, 1'b1, 1'b1);
    wait_idle();
    rx_frame(8'h00, 1'b1, 1'b0);
    wait_idle();

    // Short low glitch on idle line must be ignored.
    set_cfg(1, 0, 0);
    rxd_drv = 1'b0;
    repeat (3) tick();
    rxd_drv = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("glitch_rx_busy", rx_busy, 0);
    tick();

    // Line held low for 20 bit times: one break, then a good frame.
    begin
      rx_ev_t e;
      e = '0; e.frm = 1'b1; e.brk = 1'b1;
      rxq.push_back(e);
    end
    rxd_drv = 1'b0;
    repeat (160) tick();
    @(negedge clk);
    check("break_waits_for_idle", rx_busy, 1);
    tick();
    rxd_drv = 1'b1;
    repeat (16) tick();
    rx_frame(8'h81, 1'b0, 1'b1);
    wait_idle();

    // Overrun with the sink stalled.
    out_rdy = 1'b0;
    rx_frame(8'h11, 1'b0, 1'b1);
    rx_frame(8'h22, 1'b0, 1'b1);
    @(negedge clk);
    check("overrun_data_held", {out_vld, out_dat}, {1'b1, 8'h22});
    tick();
    out_rdy = 1'b1;
    rx_pending = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rx_valid_cleared", out_vld, 0);
    tick();

    // Reset in the middle of a TX frame.
    tx_mon_en = 1'b0;
    set_cfg(1, 0, 0);
    in_dat = 8'h00;
    in_vld = 1'b1;
    begin
      int k;
      k = 0;
      @(negedge clk);
      while (!in_rdy && k < 100) begin @(negedge clk); k++; end
    end
    @(posedge clk);
    #1 in_vld = 1'b0;
    repeat (30) tick();
    @(negedge clk);
    check("midframe_txd_busy", {txd, tx_busy}, 2'b01);
    tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_txd_rdy_busy", {txd, in_rdy, tx_busy}, 3'b100);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_mid_rst", in_rdy, 1);
    repeat (5) tick();

    check("tx_queue_drained", txq.size(), 0);
    check("rx_queue_drained", rxq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
- Parametrised, runtime-configurable AXI4-Stream full-duplex UART; next generation of the team's basic 8N1 UART.
- Adds: data width 5–9 via parameter; runtime parity selection (none/even/odd); runtime 1 or 2 stop bits; parity-error and break detection; glitch-rejecting start-bit qualification.
- Sits between the AXI-Stream fabric and the board serial pins.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9; sent LSB first.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- input_axis_tdata  input  DATA_WIDTH  TX data.
- input_axis_tvalid  input  1  TX data valid.
- input_axis_tready  output  1  TX ready.
- output_axis_tdata  output  DATA_WIDTH  RX data.
- output_axis_tvalid  output  1  RX data valid.
- output_axis_tready  input  1  RX sink ready.
- rxd  input  1  serial in; idles high; already synchronised externally.
- txd  output  1  serial out; idles high.
- tx_busy  output  1  TX frame in progress.
- rx_busy  output  1  RX frame in progress.
- rx_overrun_error  output  1  one-cycle pulse.
- rx_frame_error  output  1  one-cycle pulse.
- rx_parity_error  output  1  one-cycle pulse.
- rx_break  output  1  one-cycle pulse.
- prescale  input  16  bit period T = 8*prescale clocks; prescale 0 behaves as 1.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.

Behaviour:
- Reset is synchronous and active-high.
  - Reset values: txd=1; all other outputs 0, including input_axis_tready.
  - output_axis_tdata resets to 0.
  - Reset mid-frame aborts both TX and RX immediately; txd=1 the following cycle.
- Configuration capture:
  - prescale, parity_mode and stop_bits are sampled at TX accept (TX path) or at start-bit detection (RX path).
  - Changes mid-frame do not affect the frame in progress.
- Counter widths:
  - Prescale counter is 19 bits.
  - Bit counter is 4 bits.
  - Parity bit = XOR of the data bits (even mode), inverted for odd mode.
- TX state machine: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP1 -> STOP2 (skipped if stop_bits=0) -> IDLE.
  - IDLE: input_axis_tready=1 and tx_busy=0.
  - Accept occurs on tvalid & tready. On the next cycle: tready=0, tx_busy=1, txd=0.
  - Each bit is held exactly T cycles.
  - Frame length = T * (1 + DATA_WIDTH + P + S), where P = 1 if parity enabled else 0, and S = 1 or 2.
  - On the cycle after the last stop bit completes, tready=1 and tx_busy=0. Back-to-back frames therefore have no idle gap beyond 1 cycle.
- RX state machine: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP -> (WAIT_IDLE on error) -> IDLE.
  - IDLE -> START: rxd low in IDLE sets rx_busy=1 and loads a half-bit wait of 4*prescale-1 cycles.
  - START, at mid-bit: if rxd is still low, proceed; if high, treat as a glitch and return to IDLE with no error and no output.
  - Sampling: each subsequent bit is sampled once, at T after the previous sample (mid-bit).
  - Only the first stop bit is checked; the receiver re-arms after it regardless of stop_bits.
  - Good frame (parity matches and stop=1):
    - output_axis_tdata <= data and output_axis_tvalid <= 1.
    - If output_axis_tvalid was already 1 and not consumed that cycle, data is overwritten and rx_overrun_error pulses.
  - Parity mismatch: rx_parity_error pulses and the data is discarded.
  - Stop=0: rx_frame_error pulses and the data is discarded.
    - If additionally all data bits = 0 (and parity bit = 0 if enabled), rx_break pulses in the same cycle.
    - The FSM then enters WAIT_IDLE and re-arms only after rxd has been seen high.
  - When both parity and stop errors occur, both pulses are asserted.
  - output_axis_tvalid clears on the cycle after tvalid & tready. It holds without tready.
  - rx_busy returns to 0 on the cycle the FSM returns to IDLE.

Test Plan:
- DATA_WIDTH=8, prescale=1 (T=8), parity none, 1 stop; send 0xA5 -> txd bits 0,1,0,1,0,0,1,0,1,1, each exactly 8 cycles; tready re-asserts 81 cycles after accept; tx_busy high for 80 cycles.
- prescale=2, even parity, 2 stops; send 0x07 -> parity bit 1; frame = 12 bits × 16 = 192 cycles; a second word presented early is accepted only after the frame ends.
- Loopback rxd=txd, odd parity, prescale=1; send 0x5A, 0x00, 0xFF -> output_axis_tdata 0x5A, 0x00, 0xFF in order; no error pulses.
- Drive an RX frame 0x3C with even parity and the parity bit inverted -> single-cycle rx_parity_error; output_axis_tvalid stays 0. A 3-cycle low glitch on idle rxd (T=8) -> no rx_busy afterwards, no output, no errors.
- Hold rxd low for 20 bit times -> rx_frame_error and rx_break pulse together once; no further pulses until rxd returns high; a following valid frame 0x81 is received correctly.
- Two good frames 0x11 then 0x22 with output_axis_tready=0 -> rx_overrun_error pulses at the second frame's stop bit; tdata=0x22. Assert rst mid-TX-frame -> txd=1 and tready=0 next cycle, tready=1 after rst deasserts.
